vx_find_first_drain: RTL
========================

# vx_find_first_drain

Per-lane holding buffer and fair drain stage that sits directly upstream of the find-first priority selector. It collects up to one pending item per lane from N independent valid/ready producers. Each cycle it uses a first-valid priority scan to pick one pending lane and serializes the picks into a single registered valid/ready output stream. Batch masking bounds every lane's wait, so a continuously refilling high-priority lane cannot starve the others.

## Interface
- N, 4, number of input lanes (≥1); IDXW = max(1, clog2(N))
- DATAW, 32, payload width
- REVERSE, 0, 0 → lowest lane index has priority; 1 → highest index has priority
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  N  per-lane request
- data_in  in  N×DATAW  per-lane payload
- ready_in  out  N  per-lane accept
- valid_out  out  1  output item valid (registered)
- data_out  out  DATAW  output payload (registered)
- index_out  out  IDXW  source lane of data_out (registered)
- ready_out  in  1  downstream accept
- pending_out  out  N  current slot occupancy (status/debug)

## Operation
- State:
  - slot_valid[N] and slot_data[N]: one entry per lane
  - batch[N]: lanes in the current service round
  - output register: valid_out, data_out, index_out
- Lane intake:
  - ready_in[i] = ~slot_valid[i] while reset is high; all zeros while reset is low.
  - ready_in never depends on ready_out or on the current pick.
  - Handshake valid_in[i] & ready_in[i] sets slot_valid[i] and captures data_in[i].
- Candidate set: eff = batch if batch ≠ 0, else slot_valid.
- Pick: first set bit of eff.
  - Lowest index when REVERSE=0, highest index when REVERSE=1.
  - "any" = (eff ≠ 0).
- Output load:
  - load = any & (~valid_out | ready_out).
  - On load: data_out ← slot_data[sel], index_out ← sel, valid_out ← 1, slot_valid[sel] ← 0, batch ← eff & ~onehot(sel).
- Output drain: if valid_out & ready_out & ~any, then valid_out ← 0. data_out and index_out hold their last values.
- A lane refilled while the batch is non-empty is not in the batch. It waits until the batch empties and eff reloads from slot_valid.
- Slot clear and slot fill of the same lane cannot occur in the same cycle, because ready_in[i] is low while the slot is full.
- No payload loss or duplication. Within a batch, lanes are emitted in priority order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - slot_valid = 0, batch = 0.
  - valid_out = 0, data_out = 0, index_out = 0.
  - pending_out = 0, ready_in = 0.
- Reset mid-operation discards all slots, the batch, and any unaccepted output item.
- Latency: an input handshake in cycle t gives valid_out in cycle t+2 at the earliest, with an empty stage and ready_out high.
- Throughput: one output per cycle while any slot is pending and ready_out is high.
- Per-lane refill: a lane can be re-accepted in the cycle after its slot is drained (ready_in rises in cycle t+1 after a pick at the end of cycle t).
- Backpressure: while valid_out=1 and ready_out=0, valid_out, data_out and index_out stay stable, and no pick occurs.
- Fairness bound: a pending lane is emitted within 2N output transfers.
- Full: all slots occupied gives ready_in = 0.
- Empty: eff = 0 leaves batch at 0, and valid_out falls after the final transfer.
- N=1: batch logic degenerates, and the block behaves as a 2-deep pipeline with 50% single-lane throughput.

## Test plan
- Reset: hold reset low with all valid_in high → ready_in=0000, valid_out=0, data_out=0. Release → ready_in=1111 on the next cycle, with no spurious output.
- Single lane: N=4, DATAW=8, lane 2 presents 0xA5 in cycle 0, ready_out=1 → cycle 2 has valid_out=1, data_out=0xA5, index_out=2. ready_in[2]=0 in cycle 1 only.
- Simultaneous burst: lanes 0–3 present 0x10–0x13 in the same cycle, ready_out=1 → 4 consecutive outputs 0x10, 0x11, 0x12, 0x13 with index 0, 1, 2, 3. With REVERSE=1 → 0x13, 0x12, 0x11, 0x10.
- Fairness: lanes 0 and 3 hold valid_in high continuously, ready_out=1 → index_out sequence 0, 3, 0, 3, …, with no two consecutive 0s after the first pick.
- Backpressure: burst on all lanes, ready_out=0 for 5 cycles → valid_out=1 with data_out frozen at lane 0's payload, pending_out=1110, and ready_in low for occupied lanes. Release → the remaining items arrive in order 1, 2, 3 with no loss or duplicates.
- Reset mid-stream: assert reset while 3 slots are pending and valid_out=1 → all outputs zero immediately. After release, no stale item is ever emitted.

Source files
------------

// File: rtl/vx_find_first_drain.sv
// Per-lane holding slots feeding a registered single-stream output; lanes are
// served in batches so a lane that refills constantly cannot starve the others.
module vx_find_first_drain #(
  parameter int N       = 4,
  parameter int DATAW   = 32,
  parameter bit REVERSE = 1'b0,
  localparam int IDXW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       valid_in,
  input  logic [N*DATAW-1:0] data_in,
  output logic [N-1:0]       ready_in,
  output logic               valid_out,
  output logic [DATAW-1:0]   data_out,
  output logic [IDXW-1:0]    index_out,
  input  logic               ready_out,
  output logic [N-1:0]       pending_out
);

  logic [N-1:0]     slot_valid_reg;
  logic [DATAW-1:0] slot_data_reg [N];
  logic [N-1:0]     batch_reg;
  logic             valid_out_reg;
  logic [DATAW-1:0] data_out_reg;
  logic [IDXW-1:0]  index_out_reg;

  logic [N-1:0]     eff;
  logic [N-1:0]     sel_onehot;
  logic [IDXW-1:0]  sel;
  logic             any;
  logic             load;
  logic [N-1:0]     take;
  logic [DATAW-1:0] lane_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane_data[gi] = data_in[gi*DATAW +: DATAW];
      assign take[gi]      = valid_in[gi] & ready_in[gi];
    end
  endgenerate

  // Intake is independent of the output side; slots are closed while in reset.
  assign ready_in    = reset ? ~slot_valid_reg : '0;
  assign pending_out = slot_valid_reg;

  assign eff  = (batch_reg != '0) ? batch_reg : slot_valid_reg;
  assign any  = (eff != '0);
  assign load = any & (~valid_out_reg | ready_out);

  // Later iterations override earlier ones, so the scan order decides priority.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (REVERSE) begin
        if (eff[i]) sel = IDXW'(i);
      end else begin
        if (eff[N-1-i]) sel = IDXW'(N-1-i);
      end
    end
  end

  assign sel_onehot = N'(1) << sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_reg <= '0;
      for (int i = 0; i < N; i++) slot_data_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (take[i]) begin
          slot_valid_reg[i] <= 1'b1;
          slot_data_reg[i]  <= lane_data[i];
        end else if (load && (sel == IDXW'(i))) begin
          slot_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      batch_reg     <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      index_out_reg <= '0;
    end else if (load) begin
      batch_reg     <= eff & ~sel_onehot;
      valid_out_reg <= 1'b1;
      data_out_reg  <= slot_data_reg[sel];
      index_out_reg <= sel;
    end else if (valid_out_reg & ready_out) begin
      // Nothing left to pick: the accepted item leaves and the stage empties.
      valid_out_reg <= 1'b0;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign index_out = index_out_reg;

endmodule
